sram_march_bist: RTL

- Built-in self-test initiator for the gf180 8x1024 single-port SRAM macro.
- Drives the macro's port (csb0, web0, addr0, din0) and checks dout0.
- Runs a March C- sequence on `start` and reports pass/fail, first failing address, failing-bit syndrome and error count.
- Sits in the user project between the management/IO control and the SRAM, in place of direct pad drive.

---
 rtl/sram_march_bist.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sram_march_bist.sv
// March C- built-in self-test initiator for a single-port, read-latency-1 SRAM macro.
// Optional: define SRAM_BIST_CHECKERBOARD_EN to append a second March pass on a checkerboard background.
module sram_march_bist #(
    parameter int                 ADDR_W  = 10,
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  DATA_BG = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_syndrome,
    output logic [CNT_W-1:0]  fail_count,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    input  logic [DATA_W-1:0] sram_dout0
);

    typedef enum logic [3:0] {
        IDLE, W0, R0W1_UP, R1W0_UP, R0W1_DN, R1W0_DN, R0_UP, DRAIN, DONE
    } state_t;

    localparam logic [DATA_W-1:0] CB_EVEN = {(DATA_W/2){2'b01}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              phase, phase_nxt;
    logic              pb2, pb2_nxt;
    logic              last_addr;
    logic              start_run;

    logic              acc_en, acc_wr;
    logic [DATA_W-1:0] acc_data, bg;

    logic              cmp_vld;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic              mismatch;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_din;

    assign start_run = start && (state == IDLE || state == DONE);
    assign mismatch  = cmp_vld && (sram_dout0 != cmp_exp);
    assign bg        = pb2 ? (addr[0] ? ~CB_EVEN : CB_EVEN) : DATA_BG;

    // State register plus the datapath it sequences
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            addr          <= '0;
            phase         <= 1'b0;
            pb2           <= 1'b0;
            cmp_vld       <= 1'b0;
            cmp_exp       <= '0;
            cmp_addr      <= '0;
            hold_addr     <= '0;
            hold_din      <= '0;
            pass          <= 1'b0;
            fail_addr     <= '0;
            fail_syndrome <= '0;
            fail_count    <= '0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            phase    <= phase_nxt;
            pb2      <= pb2_nxt;
            cmp_vld  <= acc_en && !acc_wr;
            cmp_exp  <= acc_data;
            cmp_addr <= addr;
            if (acc_en)
                hold_addr <= addr;
            if (acc_en && acc_wr)
                hold_din <= acc_data;
            if (start_run) begin
                pass          <= 1'b0;
                fail_addr     <= '0;
                fail_syndrome <= '0;
                fail_count    <= '0;
            end else if (mismatch) begin
                if (fail_count == '0) begin
                    fail_addr     <= cmp_addr;
                    fail_syndrome <= cmp_exp ^ sram_dout0;
                end
                if (fail_count != '1)
                    fail_count <= fail_count + 1'b1;
            end
            // DRAIN compares the final read, so fold its result into pass
            if (state == DRAIN)
                pass <= (fail_count == '0) && !mismatch;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        phase_nxt = phase;
        pb2_nxt   = pb2;
        last_addr = (state == R0W1_DN || state == R1W0_DN) ? (addr == '0) : (addr == '1);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = W0;
                    addr_nxt  = '0;
                    phase_nxt = 1'b0;
                    pb2_nxt   = 1'b0;
                end
            end
            W0: begin
                if (last_addr) begin
                    state_nxt = R0W1_UP;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            R0W1_UP, R1W0_UP, R0W1_DN, R1W0_DN: begin
                phase_nxt = !phase;
                if (phase) begin
                    if (last_addr) begin
                        case (state)
                            R0W1_UP: begin state_nxt = R1W0_UP; addr_nxt = '0; end
                            R1W0_UP: begin state_nxt = R0W1_DN; addr_nxt = '1; end
                            R0W1_DN: begin state_nxt = R1W0_DN; addr_nxt = '1; end
                            default: begin state_nxt = R0_UP;   addr_nxt = '0; end
                        endcase
                    end else if (state == R0W1_DN || state == R1W0_DN) begin
                        addr_nxt = addr - 1'b1;
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end
            end
            R0_UP: begin
                if (last_addr) begin
`ifdef SRAM_BIST_CHECKERBOARD_EN
                    if (!pb2) begin
                        state_nxt = W0;
                        addr_nxt  = '0;
                        pb2_nxt   = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
`else
                    state_nxt = DRAIN;
`endif
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access decode; acc_data is write data on writes and expected data on reads
    always_comb begin
        acc_en   = 1'b0;
        acc_wr   = 1'b0;
        acc_data = bg;
        case (state)
            W0: begin
                acc_en = 1'b1;
                acc_wr = 1'b1;
            end
            R0W1_UP, R0W1_DN: begin
                acc_en   = 1'b1;
                acc_wr   = phase;
                acc_data = phase ? ~bg : bg;
            end
            R1W0_UP, R1W0_DN: begin
                acc_en   = 1'b1;
                acc_wr   = phase;
                acc_data = phase ? bg : ~bg;
            end
            R0_UP:   acc_en = 1'b1;
            default: acc_en = 1'b0;
        endcase
        busy       = (state != IDLE) && (state != DONE);
        done       = (state == DONE);
        sram_csb0  = !acc_en;
        sram_web0  = !(acc_en && acc_wr);
        sram_addr0 = acc_en ? addr : hold_addr;
        sram_din0  = (acc_en && acc_wr) ? acc_data : hold_din;
    end

endmodule
